// File: rtl/counter_pkg.sv
// Shared definitions for the sequential counter library: FSM state encoding
// and the common legality check on counter width.
package counter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MIN_WIDTH = 2;

    function automatic bit width_ok(input int n);
        return n >= MIN_WIDTH;
    endfunction

endpackage

// File: rtl/sync_down_counter_nbit.sv
// Loadable N-bit down counter used as an interval/timeout timer, with
// terminal-count pulse, one-shot or auto-reload behaviour and an IDLE/RUN/DONE FSM.
module sync_down_counter_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         auto_reload,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         busy,
    output logic         done,
    output logic         zero
);
    import counter_pkg::*;

    if (!width_ok(N)) begin : g_width_check
        $error("sync_down_counter_nbit: N must be at least 2");
    end

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state;
    logic [N-1:0] reload_reg;
    logic         terminal;

    assign terminal = (state == ST_RUN) && en && (Q == ONE);

    // Load always wins over counting; the unused encoding falls back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (load) begin
            state <= (load_val != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state <= ST_IDLE;
                ST_RUN:  if (terminal && !auto_reload) state <= ST_DONE;
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else if (load) begin
            Q          <= load_val;
            reload_reg <= load_val;
            tc         <= 1'b0;
        end else if (state == ST_RUN && en) begin
            if (Q == ONE) begin
                tc <= 1'b1;
                Q  <= auto_reload ? reload_reg : '0;
            end else begin
                // Zero is only reachable through a zero load, which parks in IDLE.
                tc <= 1'b0;
                if (Q != '0) Q <= Q - ONE;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign zero = (Q == '0);

endmodule

// File: tb/tb_sync_down_counter_nbit.sv
// Scoreboard bench for sync_down_counter_nbit: a behavioural model queues the
// expected outputs as stimulus is driven; they are popped after each edge.
module tb_sync_down_counter_nbit;

    logic       clk;
    logic       rst_n;
    logic       en, load, auto_reload;
    logic [7:0] load_val;
    logic [7:0] Q;
    logic       tc, busy, done, zero;

    logic       en4, load4, ar4;
    logic [3:0] lv4;
    logic [3:0] q4;
    logic       tc4, busy4, done4, zero4;

    int vecCount  = 0;
    int missCount = 0;

    logic [7:0] mq, mreload;
    int         mst;
    logic       mtc;
    logic [11:0] expQ[$];

    sync_down_counter_nbit #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .Q(Q), .tc(tc), .busy(busy), .done(done), .zero(zero)
    );

    sync_down_counter_nbit #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .load(load4), .load_val(lv4),
        .auto_reload(ar4), .Q(q4), .tc(tc4), .busy(busy4), .done(done4), .zero(zero4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] packExp(input logic [7:0] q, input logic t, input int st);
        return {q, t, st == 1, st == 2, q == 8'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got Q/tc/busy/done/zero=%h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mq = 8'd0; mreload = 8'd0; mst = 0; mtc = 1'b0;
    endtask

    // Model: 0=IDLE 1=RUN 2=DONE
    task automatic modelStep(input logic ld, input logic [7:0] lv, input logic e, input logic ar);
        if (ld) begin
            mq = lv; mreload = lv; mtc = 1'b0;
            mst = (lv != 8'd0) ? 1 : 0;
        end else if (mst == 1 && e) begin
            if (mq == 8'd1) begin
                mtc = 1'b1;
                if (ar) mq = mreload;
                else begin
                    mq = 8'd0; mst = 2;
                end
            end else begin
                mtc = 1'b0;
                mq = mq - 8'd1;
            end
        end else begin
            mtc = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic e,
                                 input logic ar, input string tag);
        @(negedge clk);
        load = ld; load_val = lv; en = e; auto_reload = ar;
        modelStep(ld, lv, e, ar);
        expQ.push_back(packExp(mq, mtc, mst));
        @(posedge clk);
        #1;
        checkOutput(tag, {Q, tc, busy, done, zero}, expQ.pop_front());
    endtask

    initial begin
        rst_n = 1'b0;
        load = 0; load_val = 0; en = 0; auto_reload = 0;
        load4 = 0; lv4 = 0; en4 = 0; ar4 = 0;
        modelReset();
        #3;
        checkOutput("reset", {Q, tc, busy, done, zero}, packExp(mq, mtc, mst));
        checkOutput("reset_n4", {4'd0, q4, tc4, busy4, done4, zero4}, 12'b0000_0000_0001);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] one-shot load 3");
        applyStimulus(1, 8'd3, 1, 0, "oneshot_load");
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'd0, 1, 0, "oneshot_run");

        $display("[TB] auto-reload load 4");
        applyStimulus(1, 8'd4, 1, 1, "reload_load");
        for (int i = 0; i < 12; i++) applyStimulus(0, 8'd0, 1, 1, "reload_run");

        $display("[TB] gated enable load 5");
        applyStimulus(1, 8'd5, 0, 0, "gated_load");
        for (int i = 0; i < 15; i++) applyStimulus(0, 8'd0, (i % 3) == 0, 0, "gated_run");

        $display("[TB] load collides with terminal");
        applyStimulus(1, 8'd2, 0, 0, "collide_load");
        applyStimulus(0, 8'd0, 1, 0, "collide_to1");
        applyStimulus(1, 8'd9, 1, 0, "collide_reload9");
        applyStimulus(0, 8'd0, 1, 0, "collide_after");
        applyStimulus(1, 8'd0, 1, 0, "load_zero");
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'd0, 1, 0, "idle_hold");

        $display("[TB] asynchronous reset mid-count");
        applyStimulus(1, 8'd8, 1, 0, "async_load");
        applyStimulus(0, 8'd0, 1, 0, "async_run7");
        applyStimulus(0, 8'd0, 1, 0, "async_run6");
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset", {Q, tc, busy, done, zero}, packExp(mq, mtc, mst));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'd0, 1, 0, "post_reset_idle");

        $display("[TB] N=4 full-range one-shot");
        @(negedge clk);
        load4 = 1; lv4 = 4'hF; en4 = 1;
        @(posedge clk); #1;
        checkOutput("n4_load", {4'd0, q4, tc4, busy4, done4, zero4}, {4'd0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        load4 = 0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            checkOutput("n4_count", {4'd0, q4, tc4, busy4, done4, zero4},
                        {4'd0, (k < 15) ? 4'(15 - k) : 4'd0, k == 15, k < 15, k >= 15, k >= 15});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
